// File: rtl/dotproduct_pkg.sv
// Shared types and default widths for the dot-product result unload path.
//   unload_state_t : result_unloader FSM states
//   DEF_*          : default parameter values for result_unloader
package dotproduct_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 4;
  localparam int unsigned DEF_PARA_DEG       = 2;
  localparam int unsigned DEF_DATA_WIDTH_OUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } unload_state_t;

endpackage

// File: rtl/unload_skid_fifo.sv
// Two-entry FIFO holding SRAM rows between the read port and the output beat.
// The head is always in mem0, so dout comes straight from a flop.
//   clk, rst_n   : clock, async active-low reset
//   push, din    : write a row (dropped if full and not popping)
//   pop          : remove head (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy flags
//   count        : occupancy 0..2
module unload_skid_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [Width-1:0] mem0;
  logic [Width-1:0] mem1;
  logic [1:0]       cnt;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Storage shifts toward mem0 on pop; push lands in the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0 <= '0;
      mem1 <= '0;
      cnt  <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) mem0 <= din;
          else             mem1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            mem0 <= mem1;
            mem1 <= din;
          end else begin
            mem0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = mem0;
  assign count = cnt;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/result_unloader.sv
// Drains the dot-product output SRAM after a run and streams its rows out as
// Para_Deg-word beats on a valid/ready interface, then pulses Done once.
// Optional feature macro: UNLOAD_CHECKSUM_EN (adds the Checksum output).
//   clk, reset_n        : clock, async active-low reset
//   Start               : begin a drain (only honoured in IDLE)
//   Rd_En, Rd_Addr      : SRAM row read request
//   Rd_Data             : SRAM row, valid one cycle after Rd_En
//   Out_Valid/Ready/Data: output beat handshake
//   Busy                : FSM not IDLE
//   Done                : one-cycle pulse after the last beat is accepted
//   Checksum            : sum of all accepted lanes (UNLOAD_CHECKSUM_EN only)
module result_unloader
  import dotproduct_pkg::*;
#(
  parameter int unsigned Addr_Width     = DEF_ADDR_WIDTH,
  parameter int unsigned Para_Deg       = DEF_PARA_DEG,
  parameter int unsigned Data_Width_Out = DEF_DATA_WIDTH_OUT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               Start,
  output logic                               Rd_En,
  output logic [Addr_Width-1:0]              Rd_Addr,
  input  logic [Para_Deg*Data_Width_Out-1:0] Rd_Data,
  output logic                               Out_Valid,
  input  logic                               Out_Ready,
  output logic [Para_Deg*Data_Width_Out-1:0] Out_Data,
  output logic                               Busy,
  output logic                               Done
`ifdef UNLOAD_CHECKSUM_EN
  ,
  output logic [Data_Width_Out+Addr_Width-1:0] Checksum
`endif
);

  localparam int unsigned Ram_Depth  = 1 << Addr_Width;
  localparam int unsigned Nums_Beats = Ram_Depth / Para_Deg;
  localparam int unsigned Row_Width  = Para_Deg * Data_Width_Out;
  localparam logic [Addr_Width-1:0] Last_Addr = Addr_Width'(Nums_Beats - 1);

  unload_state_t         state, state_nxt;
  logic [Addr_Width-1:0] rd_addr, rd_addr_nxt;
  logic [Addr_Width-1:0] beat_cnt, beat_cnt_nxt;
  logic                  pend;
  logic                  rd_en;
  logic                  room;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign pop = Out_Valid && Out_Ready;

  // A read may issue only if its row is guaranteed a FIFO slot when it lands:
  // held + in flight, less the beat leaving this cycle, must stay below 2.
  assign room = ((3'(fifo_count) + 3'(pend)) < (3'd2 + 3'(pop))) && !(fifo_full && !pop);

  // Next-state, read issue and counters.
  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    beat_cnt_nxt = beat_cnt;
    rd_en        = 1'b0;
    if (pop) beat_cnt_nxt = beat_cnt + Addr_Width'(1);
    unique case (state)
      IDLE: begin
        rd_addr_nxt  = '0;
        beat_cnt_nxt = '0;
        if (Start) state_nxt = READ;
      end
      READ: begin
        rd_en = room;
        if (rd_en) begin
          if (rd_addr == Last_Addr) state_nxt = DRAIN;
          else rd_addr_nxt = rd_addr + Addr_Width'(1);
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt == Last_Addr)) state_nxt = DONE;
      end
      DONE: begin
        rd_addr_nxt = '0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      beat_cnt <= '0;
      pend     <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_addr  <= rd_addr_nxt;
      beat_cnt <= beat_cnt_nxt;
      pend     <= rd_en;
      Busy     <= (state_nxt != IDLE);
      Done     <= (state_nxt == DONE);
    end
  end

  assign Rd_En     = rd_en;
  assign Rd_Addr   = rd_addr;
  assign Out_Valid = !fifo_empty;

  // Row read last cycle is on Rd_Data now; capture it.
  unload_skid_fifo #(
    .Width (Row_Width)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (pend),
    .pop   (pop),
    .din   (Rd_Data),
    .dout  (Out_Data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef UNLOAD_CHECKSUM_EN
  localparam int unsigned Sum_Width = Data_Width_Out + Addr_Width;

  logic [Sum_Width-1:0] beat_sum;

  // Unsigned sum of all lanes in the current head beat.
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < Para_Deg; i++) begin
      beat_sum = beat_sum + Sum_Width'(Out_Data[i*Data_Width_Out +: Data_Width_Out]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Checksum <= '0;
    end else if ((state == IDLE) && Start) begin
      Checksum <= '0;
    end else if (pop) begin
      Checksum <= Checksum + beat_sum;
    end
  end
`endif

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: SRAM row model, scoreboard queue of
// expected beats, one task per scenario. Samples are taken #1 after negedge,
// after the ready/start values for the next rising edge have been driven.
module tb_result_unloader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 2 * DW;
  localparam int NB = 8;

  logic          clk;
  logic          reset_n;
  logic          Start;
  logic          Rd_En;
  logic [AW-1:0] Rd_Addr;
  logic [RW-1:0] Rd_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [RW-1:0] Out_Data;
  logic          Busy;
  logic          Done;
`ifdef UNLOAD_CHECKSUM_EN
  logic [DW+AW-1:0] Checksum;
`endif

  int checks;
  int errors;
  logic [RW-1:0] exp_q[$];

  logic          s_valid, s_rden, s_done, s_busy, s_accept;
  logic [RW-1:0] s_data;
  logic [AW-1:0] s_addr;

  result_unloader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Start     (Start),
    .Rd_En     (Rd_En),
    .Rd_Addr   (Rd_Addr),
    .Rd_Data   (Rd_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Busy      (Busy),
    .Done      (Done)
`ifdef UNLOAD_CHECKSUM_EN
    ,
    .Checksum  (Checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row(input int k);
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    lo = DW'(2 * k);
    hi = DW'(2 * k + 1);
    return {hi, lo};
  endfunction

  // SRAM model: registered read, row k = {2k+1, 2k}.
  always @(posedge clk) begin
    if (Rd_En) Rd_Data <= row(int'(Rd_Addr));
  end

  task automatic step(input logic rdy, input logic st);
    @(negedge clk);
    Out_Ready = rdy;
    Start     = st;
    #1;
    s_valid  = Out_Valid;
    s_data   = Out_Data;
    s_rden   = Rd_En;
    s_addr   = Rd_Addr;
    s_done   = Done;
    s_busy   = Busy;
    s_accept = Out_Valid & Out_Ready;
  endtask

  task automatic load_expected();
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(row(i));
  endtask

  task automatic test_reset();
    int rd_seen;
    rd_seen = 0;
    reset_n = 1'b0; Start = 1'b0; Out_Ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({Rd_En, Rd_Addr, Out_Valid, Busy, Done} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {Rd_En, Rd_Addr, Out_Valid, Busy, Done});
    end
    checks++;
    if (Out_Data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", Out_Data);
    end
`ifdef UNLOAD_CHECKSUM_EN
    checks++;
    if (Checksum !== '0) begin
      errors++;
      $display("FAIL reset_checksum got %0d want 0", Checksum);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0);
      if (s_rden || s_busy || s_valid) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL idle_quiet got %0d active cycles want 0", rd_seen);
    end
  endtask

  task automatic test_full();
    int beats, dones, done_c, first_v;
    logic [RW-1:0] e;
    beats = 0; dones = 0; done_c = -1; first_v = -1;
    load_expected();
    step(1'b1, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step(1'b1, 1'b0);
      if (c == 1) begin
        checks++;
        if (s_busy !== 1'b1) begin
          errors++;
          $display("FAIL full_busy got %b want 1", s_busy);
        end
      end
      if (s_valid && first_v < 0) first_v = c;
      if (s_accept) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_extra_beat got %h want none", s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== e || c != beats + 3) begin
            errors++;
            $display("FAIL full_beat%0d got %h at sample %0d want %h at %0d", beats, s_data, c, e, beats + 3);
          end
        end
        beats++;
      end
      if (s_done) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
    end
    // Sample c follows edge c-1 after the Start edge.
    checks++;
    if (first_v != 3) begin
      errors++;
      $display("FAIL full_first_valid got %0d want 3", first_v);
    end
    checks++;
    if (beats != NB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_beat_count got %0d want %0d", beats, NB);
    end
    checks++;
    if (dones != 1 || done_c != NB + 3) begin
      errors++;
      $display("FAIL full_done got %0d pulses at %0d want 1 at %0d", dones, done_c, NB + 3);
    end
    checks++;
    if (s_busy !== 1'b0 || s_addr !== '0) begin
      errors++;
      $display("FAIL full_end_idle got busy=%b addr=%0d want 0 0", s_busy, s_addr);
    end
  endtask

`ifdef UNLOAD_CHECKSUM_EN
  task automatic test_checksum();
    bit fin;
    fin = 0;
    checks++;
    if (Checksum !== 20'd120) begin
      errors++;
      $display("FAIL checksum_total got %0d want 120", Checksum);
    end
    load_expected();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    checks++;
    if (Checksum !== '0) begin
      errors++;
      $display("FAIL checksum_clear got %0d want 0", Checksum);
    end
    for (int c = 0; c < 30 && !fin; c++) begin
      step(1'b1, 1'b0);
      if (s_accept && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_done) fin = 1;
    end
    step(1'b1, 1'b0);
    checks++;
    if (!fin || Checksum !== 20'd120) begin
      errors++;
      $display("FAIL checksum_rerun got %0d done=%0d want 120", Checksum, fin);
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [3:0] pat;
    int beats, issued, acc_total, dones;
    logic pv, pr;
    logic [RW-1:0] pd;
    logic [RW-1:0] e;
    bit fin;
    pat = 4'b1001;
    beats = 0; issued = 0; acc_total = 0; dones = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; fin = 0;
    load_expected();
    step(1'b1, 1'b1);
    for (int c = 0; c < 80 && !fin; c++) begin
      step(pat[c % 4], 1'b0);
      if (pv && !pr) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== pd) begin
          errors++;
          $display("FAIL bp_stall_hold got v=%b %h want v=1 %h", s_valid, s_data, pd);
        end
      end
      if (s_rden) begin
        checks++;
        if (issued - acc_total - int'(s_accept) >= 2 || s_addr !== AW'(issued)) begin
          errors++;
          $display("FAIL bp_read_issue got addr %0d outstanding %0d want addr %0d outstanding<2",
                   s_addr, issued - acc_total - int'(s_accept), issued);
        end
        issued++;
      end
      if (s_accept) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat got %h want none", s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== e) begin
            errors++;
            $display("FAIL bp_beat%0d got %h want %h", beats, s_data, e);
          end
        end
        beats++;
        acc_total++;
      end
      if (s_done) begin
        dones++;
        fin = 1;
      end
      pv = s_valid; pr = Out_Ready; pd = s_data;
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0);
      if (s_done) dones++;
    end
    checks++;
    if (!fin || beats != NB || issued != NB || dones != 1) begin
      errors++;
      $display("FAIL bp_totals got beats=%0d reads=%0d dones=%0d want %0d %0d 1", beats, issued, dones, NB, NB);
    end
  endtask

  task automatic test_start_busy();
    int beats, dones;
    bit sent;
    logic [RW-1:0] e;
    beats = 0; dones = 0; sent = 0;
    load_expected();
    step(1'b1, 1'b1);
    for (int c = 0; c < 30; c++) begin
      step(1'b1, (beats == 3 && !sent) ? 1'b1 : 1'b0);
      if (Start) sent = 1;
      if (s_accept) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (s_data !== e) begin
          errors++;
          $display("FAIL busy_beat%0d got %h want %h", beats, s_data, e);
        end
        beats++;
      end
      if (s_done) dones++;
    end
    checks++;
    if (!sent || beats != NB || dones != 1) begin
      errors++;
      $display("FAIL busy_restart got beats=%0d dones=%0d want %0d 1", beats, dones, NB);
    end
  endtask

  task automatic test_reset_mid_run();
    int beats, dones;
    logic [RW-1:0] e;
    beats = 0; dones = 0;
    load_expected();
    step(1'b1, 1'b1);
    for (int c = 0; c < 30 && beats < 5; c++) begin
      step(1'b1, 1'b0);
      if (s_accept) begin
        e = exp_q.pop_front();
        checks++;
        if (s_data !== e) begin
          errors++;
          $display("FAIL mid_beat%0d got %h want %h", beats, s_data, e);
        end
        beats++;
      end
    end
    // Beat 4 transfers on the edge inside this step.
    step(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || Rd_Addr !== '0 || Rd_En !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort got v=%b addr=%0d rden=%b busy=%b want all 0", Out_Valid, Rd_Addr, Rd_En, Busy);
    end
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0);
      if (s_done) dones++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0);
      if (s_done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d want 0", dones);
    end
    test_full();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full();
`ifdef UNLOAD_CHECKSUM_EN
    test_checksum();
`endif
    test_backpressure();
    test_start_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Reader side of the dot-product load path: after a computation finishes, drains the output SRAM and streams the results out, Para_Deg words per beat, on a valid/ready interface.
- Sits between the dotProduct output SRAM read port and the host/file-writer side; it is the counterpart of the load_from_file input path.
- Ends with a one-cycle Done pulse.

Parameters:
- Addr_Width, 4, output SRAM address width.
- Ram_Depth, 1 << Addr_Width, result words held in the output SRAM.
- Para_Deg, 2, words per SRAM row and per output beat.
- Data_Width_Out, 16, bits per result word.
- Nums_Beats, Ram_Depth / Para_Deg, SRAM rows drained per run (8 by default).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a drain; ignored unless the FSM is in IDLE.
- Rd_En  output  1  SRAM read enable.
- Rd_Addr  output  Addr_Width  SRAM row address, 0..Nums_Beats-1.
- Rd_Data  input  Para_Deg*Data_Width_Out  SRAM row; valid exactly 1 cycle after Rd_En.
- Out_Valid  output  1  Out_Data holds a valid beat.
- Out_Ready  input  1  downstream accepts the beat.
- Out_Data  output  Para_Deg*Data_Width_Out  lane i = bits [i*Data_Width_Out +: Data_Width_Out].
- Busy  output  1  high whenever the FSM is not IDLE.
- Done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, Rd_En=0, Rd_Addr=0, Out_Valid=0, Out_Data=0, Busy=0, Done=0, buffer empty, beat counters=0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on Start.
  - READ -> DRAIN in the cycle the last read (Rd_Addr = Nums_Beats-1) issues.
  - DRAIN -> DONE when the Nums_Beats-th beat is accepted (Out_Valid & Out_Ready).
  - DONE -> IDLE after exactly 1 cycle; Done=1 only in DONE.
- Read issue:
  - In READ, Rd_En=1 iff (buffer occupancy + reads in flight) < 2.
  - Rd_Addr increments by 1 after each issued read; no wrap within a run; Rd_Addr returns to 0 in IDLE.
- Buffering:
  - Rd_Data is captured the cycle after Rd_En into a 2-entry FIFO.
  - Out_Valid = FIFO not empty; Out_Data = FIFO head.
  - Beat transfer on Out_Valid & Out_Ready.
  - While Out_Valid & !Out_Ready, Out_Data is held stable.
  - Simultaneous push and pop keeps occupancy unchanged.
  - The FIFO never overflows by construction.
- Throughput and latency:
  - With Out_Ready held high: 1 beat/cycle, first Out_Valid 2 cycles after Start, Done at cycle Nums_Beats+2 after Start.
  - Per-beat latency Rd_En -> Out_Valid = 1 cycle when the FIFO is empty.
- Ordering: beats leave strictly in address order 0..Nums_Beats-1; no lane reordering; data passes through unmodified.
- Start while not IDLE: ignored; no restart, counters untouched.
- Reset mid-run: run aborted immediately, all state returns to reset values, no Done pulse; the next Start begins again at address 0.

Optional Feature:
- Macro UNLOAD_CHECKSUM_EN.
- Defined: adds output port Checksum [Data_Width_Out+Addr_Width-1:0].
  - Cleared on Start accepted in IDLE.
  - Adds every lane of every accepted beat, unsigned, with no overflow for Ram_Depth words.
  - Holds its value after Done; reset value 0.
- Undefined: no port and no logic.

Decomposition:
- Package dotproduct_pkg:
  - FSM state enum unload_state_t {IDLE, READ, DRAIN, DONE}.
  - Default width constants Addr_Width, Para_Deg, Data_Width_Out.
- Sub-module unload_skid_fifo: 2-entry FIFO with push/pop/full/empty/count, parameterised width.
- FSM and address/beat counters stay in result_unloader.

Test Plan:
- Reset and idle: reset_n=0 then release -> all outputs 0, Busy=0; no Rd_En without Start.
- Full throughput: SRAM row k = {16'(2k+1), 16'(2k)}, Out_Ready=1, Start pulse -> 8 beats in consecutive cycles, beat k lane0=2k, lane1=2k+1; Done exactly 10 cycles after Start; exactly one Done pulse.
- Backpressure: Out_Ready toggling 1,0,0,1 repeating -> no beat lost or duplicated; Out_Data stable while stalled; Rd_En never issued with 2 entries held or in flight.
- Start while busy: second Start at beat 3 -> ignored; still exactly 8 beats and one Done.
- Reset mid-run: reset_n low after beat 4 accepted -> Out_Valid=0 and Rd_Addr=0 immediately; no Done; next Start yields beats 0..7 again.
- UNLOAD_CHECKSUM_EN build with the full-throughput data -> Checksum = sum 0..15 = 120 after Done; Checksum clears on the next Start.
